joybus_reader: RTL and testbench

JOYBUS_READER -- requirements
Module: joybus_reader

---
 rtl/joybus_pkg.sv | 41 ++++
 rtl/joybus_if.sv | 31 +++
 rtl/joybus_rx_chan.sv | 134 +++++++++++++
 rtl/joybus_reader.sv | 97 +++++++++
 tb/tb_joybus_reader.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/joybus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : joybus_pkg
// Purpose  : Shared definitions for the Joybus response reader: per-channel
//            register offsets, STATUS bit positions, channel state encoding
//            and a helper that packs the STATUS word.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package joybus_pkg;

  // Register offsets inside one channel's 16-byte window
  localparam logic [3:0] OFF_DATA_HI = 4'h0;
  localparam logic [3:0] OFF_DATA_LO = 4'h4;
  localparam logic [3:0] OFF_STATUS  = 4'h8;
  localparam logic [3:0] OFF_FRAMES  = 4'hC;

  // STATUS bit positions
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RECV = 2'd1,
    CH_HOLD = 2'd2
  } ch_state_t;

  function automatic logic [31:0] status_word(input logic busy,
                                              input logic done,
                                              input logic timeout);
    logic [31:0] s;
    s              = '0;
    s[ST_BUSY]     = busy;
    s[ST_DONE]     = done;
    s[ST_TIMEOUT]  = timeout;
    return s;
  endfunction

endpackage : joybus_pkg
`default_nettype wire

// File: rtl/joybus_if.sv
`default_nettype none
// ============================================================================
// Module   : joybus_if
// Purpose  : APB3 completer bus bundle for the Joybus reader.
// Ports    : PSEL, PENABLE, PWRITE, PADDR[31:0], PWDATA[31:0] (master->slave)
//            PRDATA[31:0], PREADY, PSLVERR                   (slave->master)
// Revision : 1.0 - initial release
// ============================================================================
interface joybus_if;

  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface : joybus_if
`default_nettype wire

// File: rtl/joybus_rx_chan.sv
`default_nettype none
// ============================================================================
// Module   : joybus_rx_chan
// Purpose  : One Joybus response receiver channel: 2-flop line synchronizer,
//            IDLE/RECV/HOLD state machine, bit-cell counter, MSB-first shift
//            register, shadow register, frame counter and done/timeout flags.
// Ports    : clk, rst_n           clock, async active-low reset
//            ready                channel enable (poll command sent)
//            data                 asynchronous serial line
//            done_clr/timeout_clr W1C clear strobes from the register block
//            sample               one-cycle pulse at every bit sample point
//            busy/done/timeout    status bits
//            shadow[63:0]         last complete frame, right-aligned
//            frames[15:0]         completed-frame count (wrapping)
// Revision : 1.0 - initial release
// ============================================================================
module joybus_rx_chan
  import joybus_pkg::*;
#(
  parameter int RESP_BITS   = 64,
  parameter int CLK_PER_BIT = 400,
  parameter int SAMPLE_PT   = 200,
  parameter int TIMEOUT_CYC = 1200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ready,
  input  logic        data,
  input  logic        done_clr,
  input  logic        timeout_clr,
  output logic        sample,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [63:0] shadow,
  output logic [15:0] frames
);

  // The counter must reach the timeout value and span a full bit cell.
  localparam int CNT_MAX = (TIMEOUT_CYC > CLK_PER_BIT) ? TIMEOUT_CYC : CLK_PER_BIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(RESP_BITS);

  localparam logic [CNT_W-1:0] C_SAMPLE  = CNT_W'(SAMPLE_PT);
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] C_LAST    = IDX_W'(RESP_BITS - 1);

  ch_state_t              state;
  logic                   sync_meta;
  logic                   sync_q;
  logic                   sync_d;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       bit_idx;
  // Holds the first RESP_BITS-1 bits; the last bit is taken straight from the
  // synchronizer when the frame is copied to the shadow.
  logic [RESP_BITS-2:0]   shift;
  logic [RESP_BITS-1:0]   shadow_r;
  logic [15:0]            frame_cnt;

  logic fall;
  assign fall = sync_d & ~sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b1;
      sync_q    <= 1'b1;
      sync_d    <= 1'b1;
      state     <= CH_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      shadow_r  <= '0;
      frame_cnt <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      sample    <= 1'b0;
    end else begin
      sync_meta <= data;
      sync_q    <= sync_meta;
      sync_d    <= sync_q;
      sample    <= 1'b0;

      // Clears first; a set further down in the same cycle overrides them.
      if (done_clr)    done    <= 1'b0;
      if (timeout_clr) timeout <= 1'b0;

      case (state)
        CH_IDLE: begin
          if (ready && fall) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= CH_RECV;
          end
        end

        CH_RECV: begin
          if (!ready) begin
            state <= CH_IDLE;
          end else if (cnt == C_TIMEOUT) begin
            // Partial frame is dropped; shadow keeps the previous frame.
            timeout <= 1'b1;
            state   <= CH_HOLD;
          end else begin
            cnt <= fall ? '0 : cnt + CNT_W'(1);
            if (cnt == C_SAMPLE) begin
              shift   <= {shift[RESP_BITS-3:0], sync_q};
              sample  <= 1'b1;
              bit_idx <= bit_idx + IDX_W'(1);
              if (bit_idx == C_LAST) begin
                shadow_r  <= {shift, sync_q};
                done      <= 1'b1;
                frame_cnt <= frame_cnt + 16'd1;
                state     <= CH_HOLD;
              end
            end
          end
        end

        CH_HOLD: begin
          // Line activity (stop bit included) is ignored until ready drops.
          if (!ready) state <= CH_IDLE;
        end

        default: state <= CH_IDLE;
      endcase
    end
  end

  assign busy   = (state == CH_RECV);
  assign shadow = 64'(shadow_r);
  assign frames = frame_cnt;

endmodule : joybus_rx_chan
`default_nettype wire

// File: rtl/joybus_reader.sv
`default_nettype none
// ============================================================================
// Module   : joybus_reader
// Purpose  : Multi-channel Joybus controller response reader with an APB3
//            register interface. Each channel captures RESP_BITS response
//            bits into a shadow register readable over APB.
// Ports    : PCLK, PRESERN        clock, async active-low reset
//            apb (slave)          APB3 bus, PADDR[7:0] decoded
//            ready[NUM_CH-1:0]    per-channel enable
//            data[NUM_CH-1:0]     per-channel serial lines
//            sample[NUM_CH-1:0]   per-channel sample-point pulses
// Register map (channel c at 0x10*c):
//            +0x0 DATA_HI  +0x4 DATA_LO  +0x8 STATUS (W1C)  +0xC FRAMES
// Revision : 1.0 - initial release
// ============================================================================
module joybus_reader
  import joybus_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int RESP_BITS   = 64,
  parameter int CLK_PER_BIT = 400,
  parameter int SAMPLE_PT   = 200,
  parameter int TIMEOUT_CYC = 1200
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  joybus_if.slave           apb,
  input  logic [NUM_CH-1:0] ready,
  input  logic [NUM_CH-1:0] data,
  output logic [NUM_CH-1:0] sample
);

  logic [3:0]        ch_sel;
  logic [3:0]        reg_off;
  logic              wr_status;
  logic [NUM_CH-1:0] busy_a;
  logic [NUM_CH-1:0] done_a;
  logic [NUM_CH-1:0] timeout_a;
  logic [NUM_CH-1:0] done_clr;
  logic [NUM_CH-1:0] timeout_clr;
  logic [63:0]       shadow_a [NUM_CH];
  logic [15:0]       frames_a [NUM_CH];

  assign ch_sel    = apb.PADDR[7:4];
  assign reg_off   = apb.PADDR[3:0];
  assign wr_status = apb.PSEL & apb.PENABLE & apb.PWRITE & (reg_off == OFF_STATUS);

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;

  // Address/data bits outside the decoded range
  logic unused_bits;
  assign unused_bits = ^{apb.PADDR[31:8], apb.PWDATA[31:3], apb.PWDATA[0]};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign done_clr[c]    = wr_status & (ch_sel == 4'(c)) & apb.PWDATA[ST_DONE];
    assign timeout_clr[c] = wr_status & (ch_sel == 4'(c)) & apb.PWDATA[ST_TIMEOUT];

    joybus_rx_chan #(
      .RESP_BITS   (RESP_BITS),
      .CLK_PER_BIT (CLK_PER_BIT),
      .SAMPLE_PT   (SAMPLE_PT),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_chan (
      .clk         (PCLK),
      .rst_n       (PRESERN),
      .ready       (ready[c]),
      .data        (data[c]),
      .done_clr    (done_clr[c]),
      .timeout_clr (timeout_clr[c]),
      .sample      (sample[c]),
      .busy        (busy_a[c]),
      .done        (done_a[c]),
      .timeout     (timeout_a[c]),
      .shadow      (shadow_a[c]),
      .frames      (frames_a[c])
    );
  end

  // Read mux: channels at or above NUM_CH fall through to zero.
  always_comb begin
    apb.PRDATA = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == 4'(c)) begin
        case (reg_off)
          OFF_DATA_HI: apb.PRDATA = shadow_a[c][63:32];
          OFF_DATA_LO: apb.PRDATA = shadow_a[c][31:0];
          OFF_STATUS:  apb.PRDATA = status_word(busy_a[c], done_a[c], timeout_a[c]);
          OFF_FRAMES:  apb.PRDATA = {16'h0000, frames_a[c]};
          default:     ;
        endcase
      end
    end
  end

endmodule : joybus_reader
`default_nettype wire

// File: tb/tb_joybus_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_joybus_reader
// Purpose  : Self-checking bench for joybus_reader: Joybus bit cells are
//            driven on the serial lines, expected register contents are
//            queued as frames are sent and compared over APB afterwards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_joybus_reader;

  localparam int NUM_CH      = 4;
  localparam int RESP_BITS   = 64;
  localparam int CLK_PER_BIT = 400;
  localparam int SAMPLE_PT   = 200;
  localparam int TIMEOUT_CYC = 1200;
  localparam int LOW_ONE     = CLK_PER_BIT / 4;
  localparam int LOW_ZERO    = 3 * CLK_PER_BIT / 4;
  localparam int WAIT_LIMIT  = 40000;

  logic              PCLK = 1'b0;
  logic              PRESERN;
  logic [NUM_CH-1:0] ready;
  logic [NUM_CH-1:0] data_line;
  logic [NUM_CH-1:0] sample;

  joybus_if apb_bus ();

  joybus_reader #(
    .NUM_CH      (NUM_CH),
    .RESP_BITS   (RESP_BITS),
    .CLK_PER_BIT (CLK_PER_BIT),
    .SAMPLE_PT   (SAMPLE_PT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .PCLK    (PCLK),
    .PRESERN (PRESERN),
    .apb     (apb_bus),
    .ready   (ready),
    .data    (data_line),
    .sample  (sample)
  );

  always #5 PCLK = ~PCLK;

  int n_vec = 0;
  int n_err = 0;
  int s_cnt [NUM_CH];

  always @(negedge PCLK) begin
    for (int c = 0; c < NUM_CH; c++)
      if (sample[c]) s_cnt[c]++;
  end

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expect_rd(input logic [7:0] addr, input logic [31:0] val);
    exp_t e;
    e.addr = addr;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic apb_read(input logic [7:0] addr, output logic [31:0] rd);
    @(negedge PCLK);
    apb_bus.PSEL    = 1'b1;
    apb_bus.PENABLE = 1'b0;
    apb_bus.PWRITE  = 1'b0;
    apb_bus.PADDR   = {24'h0, addr};
    @(negedge PCLK);
    apb_bus.PENABLE = 1'b1;
    @(negedge PCLK);
    rd = apb_bus.PRDATA;
    apb_bus.PSEL    = 1'b0;
    apb_bus.PENABLE = 1'b0;
  endtask

  // Setup phase at the first negedge, write takes effect at the second
  // following posedge.
  task automatic apb_write(input logic [7:0] addr, input logic [31:0] wd);
    @(negedge PCLK);
    apb_bus.PSEL    = 1'b1;
    apb_bus.PENABLE = 1'b0;
    apb_bus.PWRITE  = 1'b1;
    apb_bus.PADDR   = {24'h0, addr};
    apb_bus.PWDATA  = wd;
    @(negedge PCLK);
    apb_bus.PENABLE = 1'b1;
    @(negedge PCLK);
    apb_bus.PSEL    = 1'b0;
    apb_bus.PENABLE = 1'b0;
    apb_bus.PWRITE  = 1'b0;
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] rd;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      apb_read(e.addr, rd);
      chk($sformatf("rd_%02h", e.addr), rd, e.val);
    end
  endtask

  // Joybus cell: falling edge, low 1/4 cell for '1' or 3/4 cell for '0'.
  // With stall set, the line is left low after nbits cells.
  task automatic send_frame(input int ch, input logic [63:0] v, input int nbits, input bit stall);
    int low;
    for (int b = 0; b < nbits; b++) begin
      low = v[RESP_BITS-1-b] ? LOW_ONE : LOW_ZERO;
      for (int k = 0; k < CLK_PER_BIT; k++) begin
        data_line[ch] = (k < low) ? 1'b0 : 1'b1;
        @(negedge PCLK);
      end
    end
    if (stall) begin
      data_line[ch] = 1'b0;
    end else begin
      for (int k = 0; k < CLK_PER_BIT; k++) begin
        data_line[ch] = (k < LOW_ONE) ? 1'b0 : 1'b1;
        @(negedge PCLK);
      end
    end
  endtask

  task automatic wait_samples(input int ch, input int n, output int seen);
    int guard;
    seen  = 0;
    guard = 0;
    while (seen < n && guard < WAIT_LIMIT) begin
      @(negedge PCLK);
      guard++;
      if (sample[ch]) seen++;
    end
  endtask

  initial begin
    int          k;
    logic [31:0] rd;
    int          base [NUM_CH];

    apb_bus.PSEL    = 1'b0;
    apb_bus.PENABLE = 1'b0;
    apb_bus.PWRITE  = 1'b0;
    apb_bus.PADDR   = '0;
    apb_bus.PWDATA  = '0;
    ready           = '0;
    data_line       = '1;
    PRESERN         = 1'b0;
    repeat (4) @(negedge PCLK);

    // ---------------- reset state ----------------
    for (int c = 0; c < NUM_CH; c++)
      for (int r = 0; r < 4; r++)
        expect_rd(8'(16 * c + 4 * r), 32'h0);
    expect_rd(8'h50, 32'h0);
    drain();
    PRESERN = 1'b1;
    repeat (4) @(negedge PCLK);

    // ------- ch0 full frame, ch1 stalls after 10 bits -------
    for (int c = 0; c < NUM_CH; c++) base[c] = s_cnt[c];
    expect_rd(8'h00, 32'h1F80_8080);
    expect_rd(8'h04, 32'h2020_0000);
    expect_rd(8'h08, 32'h0000_0002);
    expect_rd(8'h0C, 32'h0000_0001);
    expect_rd(8'h10, 32'h0);
    expect_rd(8'h14, 32'h0);
    expect_rd(8'h18, 32'h0000_0004);
    expect_rd(8'h1C, 32'h0);
    ready[1:0] = 2'b11;
    @(negedge PCLK);
    fork
      send_frame(0, 64'h1F80_8080_2020_0000, 64, 1'b0);
      send_frame(1, 64'h5A5A_0000_0000_0000, 10, 1'b1);
      begin
        wait_samples(0, 5, k);
        chk("busy_wait", 32'(k), 32'd5);
        apb_read(8'h08, rd);
        chk("busy_ch0", rd, 32'h1);
        apb_read(8'h18, rd);
        chk("busy_ch1", rd, 32'h1);
      end
    join
    drain();
    chk("samples_ch0", 32'(s_cnt[0] - base[0]), 32'd64);
    chk("samples_ch1", 32'(s_cnt[1] - base[1]), 32'd11);

    data_line[1] = 1'b1;
    ready        = '0;
    @(negedge PCLK);
    apb_write(8'h08, 32'h6);
    apb_write(8'h18, 32'h4);
    expect_rd(8'h08, 32'h0);
    expect_rd(8'h18, 32'h0);
    expect_rd(8'h00, 32'h1F80_8080);
    drain();

    // ------- reset in the middle of a frame (bit 30) -------
    ready[0] = 1'b1;
    @(negedge PCLK);
    fork
      send_frame(0, 64'hC3C3_C3C3_C3C3_C3C3, 35, 1'b0);
      begin
        wait_samples(0, 30, k);
        chk("rst_wait", 32'(k), 32'd30);
        PRESERN = 1'b0;
        ready   = '0;
        apb_read(8'h00, rd);
        chk("rst_async_hi", rd, 32'h0);
        repeat (3) @(negedge PCLK);
        PRESERN = 1'b1;
      end
    join
    data_line = '1;
    for (int c = 0; c < NUM_CH; c++)
      for (int r = 0; r < 4; r++)
        expect_rd(8'(16 * c + 4 * r), 32'h0);
    drain();

    // ---- all channels complete together; W1C collides on ch3; ch2 wraps ----
    force dut.g_ch[2].u_chan.frame_cnt = 16'hFFFF;
    @(negedge PCLK);
    release dut.g_ch[2].u_chan.frame_cnt;
    expect_rd(8'h2C, 32'h0000_FFFF);
    drain();

    for (int c = 0; c < NUM_CH; c++) base[c] = s_cnt[c];
    ready = '1;
    @(negedge PCLK);
    fork
      send_frame(0, 64'h0123_4567_89AB_CDEF, 64, 1'b0);
      send_frame(1, 64'hFEDC_BA98_7654_3210, 64, 1'b0);
      send_frame(2, 64'hDEAD_BEEF_CAFE_F00D, 64, 1'b0);
      send_frame(3, 64'h8000_0000_0000_0001, 64, 1'b0);
      begin
        // The 64th sample edge is exactly one cell after the 63rd.
        wait_samples(3, 63, k);
        chk("w1c_sync", 32'(k), 32'd63);
        repeat (CLK_PER_BIT - 3) @(negedge PCLK);
        apb_write(8'h38, 32'h2);
      end
    join
    expect_rd(8'h00, 32'h0123_4567);
    expect_rd(8'h04, 32'h89AB_CDEF);
    expect_rd(8'h08, 32'h2);
    expect_rd(8'h0C, 32'h1);
    expect_rd(8'h10, 32'hFEDC_BA98);
    expect_rd(8'h14, 32'h7654_3210);
    expect_rd(8'h18, 32'h2);
    expect_rd(8'h1C, 32'h1);
    expect_rd(8'h20, 32'hDEAD_BEEF);
    expect_rd(8'h24, 32'hCAFE_F00D);
    expect_rd(8'h28, 32'h2);
    expect_rd(8'h2C, 32'h0);
    expect_rd(8'h30, 32'h8000_0000);
    expect_rd(8'h34, 32'h0000_0001);
    expect_rd(8'h38, 32'h2);
    expect_rd(8'h3C, 32'h1);
    expect_rd(8'h50, 32'h0);
    expect_rd(8'hFC, 32'h0);
    drain();
    for (int c = 0; c < NUM_CH; c++)
      chk($sformatf("samples_b_ch%0d", c), 32'(s_cnt[c] - base[c]), 32'd64);

    // Plain W1C and writes that must have no effect
    apb_write(8'h08, 32'h2);
    apb_write(8'h18, 32'h1);
    apb_write(8'h14, 32'hFFFF_FFFF);
    apb_write(8'h58, 32'h6);
    expect_rd(8'h08, 32'h0);
    expect_rd(8'h18, 32'h2);
    expect_rd(8'h14, 32'h7654_3210);
    expect_rd(8'h28, 32'h2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_joybus_reader
`default_nettype wire
